mem_channel_arbiter: RTL and testbench
======================================

Name: mem_channel_arbiter

Overview:
- Shares M data-memory channels between N requesters: core LSU lanes, i.e. the per-thread data_mem_* ports of every core.
- Sits between the cores and external data memory.
- Each channel runs its own handshake FSM and picks requesters round-robin.
- One requester is held by at most one channel at a time.

Parameters:
ADDR_BITS, 8, data memory address width
DATA_BITS, 8, data memory word width
NUM_CONSUMERS, 4, number of requester lanes (>=1)
NUM_CHANNELS, 1, number of memory channels (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
consumer_read_valid  input  [NUM_CONSUMERS]  read request per lane
consumer_read_address  input  [NUM_CONSUMERS] x ADDR_BITS  read address
consumer_read_ready  output  [NUM_CONSUMERS]  read complete, data valid
consumer_read_data  output  [NUM_CONSUMERS] x DATA_BITS  returned read data
consumer_write_valid  input  [NUM_CONSUMERS]  write request per lane
consumer_write_address  input  [NUM_CONSUMERS] x ADDR_BITS  write address
consumer_write_data  input  [NUM_CONSUMERS] x DATA_BITS  write data
consumer_write_ready  output  [NUM_CONSUMERS]  write complete
mem_read_valid  output  [NUM_CHANNELS]  read request to memory
mem_read_address  output  [NUM_CHANNELS] x ADDR_BITS  read address
mem_read_ready  input  [NUM_CHANNELS]  memory read done, data valid
mem_read_data  input  [NUM_CHANNELS] x DATA_BITS  memory read data
mem_write_valid  output  [NUM_CHANNELS]  write request to memory
mem_write_address  output  [NUM_CHANNELS] x ADDR_BITS  write address
mem_write_data  output  [NUM_CHANNELS] x DATA_BITS  write data
mem_write_ready  input  [NUM_CHANNELS]  memory write done

Behaviour:
- Single clock clk; reset synchronous active-high.
- All outputs registered. On reset:
  - every output is 0;
  - every channel FSM is IDLE;
  - claim mask is 0;
  - rr_ptr[c] = c mod NUM_CONSUMERS.
- Per-channel FSM states: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
- IDLE:
  - Scan lanes starting at rr_ptr[c], wrapping modulo NUM_CONSUMERS.
  - Select the first lane with read_valid|write_valid that is not claimed.
  - If a lane has both read and write valid, read wins.
  - On grant, latch address (and data for writes) into the mem_* outputs, set mem_*_valid=1, set the claim bit, record the granted lane, and go to READ_WAIT or WRITE_WAIT.
- Same-cycle arbitration: channels resolve in ascending index. Claims made by lower channels in a cycle are visible to higher channels in the same cycle, so one lane is never granted twice.
- READ_WAIT / WRITE_WAIT:
  - Hold mem outputs until mem_*_ready=1.
  - Then clear mem_*_valid.
  - For reads, copy mem_read_data into consumer_read_data[lane].
  - Set consumer_*_ready[lane]=1 and go to the matching RELAY state.
- RELAY:
  - Hold consumer ready until the lane's matching valid is seen low.
  - Then clear ready, clear the claim bit, set rr_ptr[c]=(lane+1) mod NUM_CONSUMERS, and go to IDLE.
  - The channel can re-grant no earlier than the cycle after IDLE is entered.
- Latency:
  - request sampled at edge t;
  - mem valid high after t;
  - mem ready sampled at edge t+k;
  - consumer ready high after t+k;
  - minimum 2 cycles request-to-ready with zero-wait memory.
- consumer_read_data[lane] holds its value until the next read completion on that lane.
- Lane drops valid while in WAIT: the transaction still completes. Ready pulses for exactly one cycle, then the claim is released.
- mem_*_ready arriving while the channel is not in WAIT is ignored.
- NUM_CHANNELS > NUM_CONSUMERS: surplus channels stay IDLE.
- NUM_CONSUMERS=1: rr_ptr is constant 0.
- Reset mid-transaction: the next edge forces reset state. The outstanding memory request is abandoned and no ready is returned.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds output perf_grant_count [16]: a saturating count of grants across all channels, incremented by the number of grants in the cycle and stopping at 16'hFFFF.
  - Adds output perf_stall_count [16]: a saturating count of cycles in which at least one unclaimed lane is requesting but no channel is IDLE.
  - Both counters reset to 0.
- Undefined: neither port nor the counter logic exists, and the remaining behaviour is identical.

Test Plan:
- N=4, M=1, all lanes read-valid at reset release; memory ready 1 cycle after valid, data = 8'hA0+address; addresses 0..3 -> grants in order lane0,1,2,3; each lane gets data A0..A3; no overlapping mem_read_valid.
- N=4, M=2, lanes 0 and 1 request in the same cycle -> channel0 serves lane0, channel1 serves lane1 in the same cycle; no lane receives two grants.
- Lane2 holds both read and write valid (address 8'h10, write data 8'h55) -> read issued first; write issued only after the read relay completes and the lane re-requests.
- Write with mem_write_ready delayed 5 cycles -> mem_write_valid held 5 cycles; consumer_write_ready rises the cycle after ready and stays high until write_valid drops.
- Reset asserted during READ_WAIT -> all outputs 0 at the next edge; after reset release, arbitration restarts from rr_ptr reset values.
- With MEM_ARB_PERF_EN: 3 reads served, plus 2 cycles of a requester waiting while the single channel is busy -> perf_grant_count=3, perf_stall_count=2.

Source files
------------

// File: rtl/mem_channel_arbiter.sv
// Purpose : shares NUM_CHANNELS data-memory channels among NUM_CONSUMERS LSU lanes,
//           with a round-robin handshake FSM per channel.
// Latency : at least 2 cycles from request to consumer ready with zero-wait memory.
//           The request edge is followed by mem valid, and the mem ready edge by consumer ready.
// Backpr. : mem outputs hold until mem ready. Consumer ready holds until the lane drops its valid.
//           Lanes that are not granted simply wait.
//
// Ports   : clk/reset (sync, active-high); consumer_* lane-side read/write request,
//           address, data and completion per lane (packed, lane i at [i*W +: W]);
//           mem_* channel-side request/completion per channel (packed, channel c at [c*W +: W]).
// Option  : define MEM_ARB_PERF_EN to add perf_grant_count / perf_stall_count (16-bit, saturating).
module mem_channel_arbiter #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 4,
   parameter int NUM_CHANNELS  = 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
`ifdef MEM_ARB_PERF_EN
   output logic [15:0]                          perf_grant_count,
   output logic [15:0]                          perf_stall_count,
`endif
   input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]              mem_read_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]    mem_read_address,
   input  logic [NUM_CHANNELS-1:0]              mem_read_ready,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0]    mem_read_data,
   output logic [NUM_CHANNELS-1:0]              mem_write_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]    mem_write_address,
   output logic [NUM_CHANNELS*DATA_BITS-1:0]    mem_write_data,
   input  logic [NUM_CHANNELS-1:0]              mem_write_ready
);

   localparam int LW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [2:0] {IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY} state_t;

   state_t                            state_q [NUM_CHANNELS];
   state_t                            state_d [NUM_CHANNELS];
   logic [LW-1:0]                     lane_q  [NUM_CHANNELS];
   logic [LW-1:0]                     lane_d  [NUM_CHANNELS];
   logic [LW-1:0]                     rr_q    [NUM_CHANNELS];
   logic [LW-1:0]                     rr_d    [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0]          claim_q, claim_d;
   // Claims as seen while walking the channels: includes this cycle's grants, but
   // not this cycle's releases, so a lane is never granted twice in one cycle.
   logic [NUM_CONSUMERS-1:0]          taken;
   logic                              found;
   int                                sel;
   int                                idx;

   logic [NUM_CONSUMERS-1:0]           consumer_read_ready_d, consumer_write_ready_d;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_d;
   logic [NUM_CHANNELS-1:0]            mem_read_valid_d, mem_write_valid_d;
   logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address_d, mem_write_address_d;
   logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data_d;

   always_comb begin
      state_d                = state_q;
      lane_d                 = lane_q;
      rr_d                   = rr_q;
      claim_d                = claim_q;
      taken                  = claim_q;
      found                  = 1'b0;
      sel                    = 0;
      idx                    = 0;
      consumer_read_ready_d  = consumer_read_ready;
      consumer_write_ready_d = consumer_write_ready;
      consumer_read_data_d   = consumer_read_data;
      mem_read_valid_d       = mem_read_valid;
      mem_write_valid_d      = mem_write_valid;
      mem_read_address_d     = mem_read_address;
      mem_write_address_d    = mem_write_address;
      mem_write_data_d       = mem_write_data;

      // Channels resolve in ascending order so lower channels claim first.
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         case (state_q[c])
            IDLE: begin
               found = 1'b0;
               sel   = 0;
               // Channels beyond the lane count could never hold a distinct lane.
               if (c < NUM_CONSUMERS) begin
                  for (int i = 0; i < NUM_CONSUMERS; i++) begin
                     idx = int'(rr_q[c]) + i;
                     if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
                     if (!found && !taken[idx] &&
                         (consumer_read_valid[idx] || consumer_write_valid[idx])) begin
                        found = 1'b1;
                        sel   = idx;
                     end
                  end
               end
               if (found) begin
                  taken[sel]   = 1'b1;
                  claim_d[sel] = 1'b1;
                  lane_d[c]    = LW'(sel);
                  if (consumer_read_valid[sel]) begin
                     mem_read_valid_d[c] = 1'b1;
                     mem_read_address_d[c*ADDR_BITS +: ADDR_BITS] =
                        consumer_read_address[sel*ADDR_BITS +: ADDR_BITS];
                     state_d[c] = READ_WAIT;
                  end else begin
                     mem_write_valid_d[c] = 1'b1;
                     mem_write_address_d[c*ADDR_BITS +: ADDR_BITS] =
                        consumer_write_address[sel*ADDR_BITS +: ADDR_BITS];
                     mem_write_data_d[c*DATA_BITS +: DATA_BITS] =
                        consumer_write_data[sel*DATA_BITS +: DATA_BITS];
                     state_d[c] = WRITE_WAIT;
                  end
               end
            end
            READ_WAIT: begin
               if (mem_read_ready[c]) begin
                  mem_read_valid_d[c] = 1'b0;
                  consumer_read_data_d[lane_q[c]*DATA_BITS +: DATA_BITS] =
                     mem_read_data[c*DATA_BITS +: DATA_BITS];
                  consumer_read_ready_d[lane_q[c]] = 1'b1;
                  state_d[c] = READ_RELAY;
               end
            end
            WRITE_WAIT: begin
               if (mem_write_ready[c]) begin
                  mem_write_valid_d[c]              = 1'b0;
                  consumer_write_ready_d[lane_q[c]] = 1'b1;
                  state_d[c]                        = WRITE_RELAY;
               end
            end
            READ_RELAY: begin
               if (!consumer_read_valid[lane_q[c]]) begin
                  consumer_read_ready_d[lane_q[c]] = 1'b0;
                  claim_d[lane_q[c]]               = 1'b0;
                  rr_d[c]    = (lane_q[c] == LW'(NUM_CONSUMERS-1)) ? '0 : lane_q[c] + 1'b1;
                  state_d[c] = IDLE;
               end
            end
            WRITE_RELAY: begin
               if (!consumer_write_valid[lane_q[c]]) begin
                  consumer_write_ready_d[lane_q[c]] = 1'b0;
                  claim_d[lane_q[c]]                = 1'b0;
                  rr_d[c]    = (lane_q[c] == LW'(NUM_CONSUMERS-1)) ? '0 : lane_q[c] + 1'b1;
                  state_d[c] = IDLE;
               end
            end
            default: state_d[c] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_q[c] <= IDLE;
            lane_q[c]  <= '0;
            rr_q[c]    <= LW'(c % NUM_CONSUMERS);
         end
         claim_q              <= '0;
         consumer_read_ready  <= '0;
         consumer_write_ready <= '0;
         consumer_read_data   <= '0;
         mem_read_valid       <= '0;
         mem_write_valid      <= '0;
         mem_read_address     <= '0;
         mem_write_address    <= '0;
         mem_write_data       <= '0;
      end else begin
         state_q              <= state_d;
         lane_q               <= lane_d;
         rr_q                 <= rr_d;
         claim_q              <= claim_d;
         consumer_read_ready  <= consumer_read_ready_d;
         consumer_write_ready <= consumer_write_ready_d;
         consumer_read_data   <= consumer_read_data_d;
         mem_read_valid       <= mem_read_valid_d;
         mem_write_valid      <= mem_write_valid_d;
         mem_read_address     <= mem_read_address_d;
         mem_write_address    <= mem_write_address_d;
         mem_write_data       <= mem_write_data_d;
      end
   end

`ifdef MEM_ARB_PERF_EN
   logic [15:0] grants;
   logic        any_idle;
   logic        stall_hit;
   logic [16:0] grant_sum;

   // A grant is exactly an IDLE channel leaving IDLE this cycle.
   always_comb begin
      grants   = '0;
      any_idle = 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (state_q[c] == IDLE) any_idle = 1'b1;
         if (state_q[c] == IDLE && state_d[c] != IDLE) grants = grants + 16'd1;
      end
      stall_hit = (|((consumer_read_valid | consumer_write_valid) & ~claim_q)) && !any_idle;
      grant_sum = {1'b0, perf_grant_count} + {1'b0, grants};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_grant_count <= '0;
         perf_stall_count <= '0;
      end else begin
         perf_grant_count <= grant_sum[16] ? 16'hFFFF : grant_sum[15:0];
         if (stall_hit && perf_stall_count != 16'hFFFF)
            perf_stall_count <= perf_stall_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Purpose : directed table-driven bench for mem_channel_arbiter (N=4,M=1 and N=4,M=2 instances).
// Latency : checks land #1 after each rising edge; the memory models respond on the falling edge.
// Backpr. : memory models raise ready after a programmable count of cycles with valid high.
`define CHK(n, a, e) check(n, 64'(a), 64'(e))

module tb_mem_channel_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // ---------------- DUT A: 4 lanes, 1 channel ----------------
   logic        a_reset   = 1'b1;
   logic [3:0]  a_rd_vld  = '0;
   logic [3:0]  a_wr_vld  = '0;
   logic [31:0] a_rd_addr = 32'h03020100;
   logic [31:0] a_wr_addr = '0;
   logic [31:0] a_wr_dat  = '0;
   logic [3:0]  a_crr, a_cwr;
   logic [31:0] a_rdata;
   logic        a_mrv, a_mwv;
   logic [7:0]  a_mraddr, a_mwaddr, a_mwdat;
   logic        a_mrrdy = 1'b0;
   logic        a_mwrdy = 1'b0;
   logic [7:0]  a_mrdat = '0;
`ifdef MEM_ARB_PERF_EN
   logic [15:0] a_pg, a_ps;
`endif

   mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) u_a (
      .clk                    (clk),
      .reset                  (a_reset),
`ifdef MEM_ARB_PERF_EN
      .perf_grant_count       (a_pg),
      .perf_stall_count       (a_ps),
`endif
      .consumer_read_valid    (a_rd_vld),
      .consumer_read_address  (a_rd_addr),
      .consumer_read_ready    (a_crr),
      .consumer_read_data     (a_rdata),
      .consumer_write_valid   (a_wr_vld),
      .consumer_write_address (a_wr_addr),
      .consumer_write_data    (a_wr_dat),
      .consumer_write_ready   (a_cwr),
      .mem_read_valid         (a_mrv),
      .mem_read_address       (a_mraddr),
      .mem_read_ready         (a_mrrdy),
      .mem_read_data          (a_mrdat),
      .mem_write_valid        (a_mwv),
      .mem_write_address      (a_mwaddr),
      .mem_write_data         (a_mwdat),
      .mem_write_ready        (a_mwrdy)
   );

   // ---------------- DUT B: 4 lanes, 2 channels ----------------
   logic        b_reset   = 1'b1;
   logic [3:0]  b_rd_vld  = '0;
   logic [31:0] b_rd_addr = '0;
   logic [3:0]  b_crr, b_cwr;
   logic [31:0] b_rdata;
   logic [1:0]  b_mrv, b_mwv;
   logic [15:0] b_mraddr, b_mwaddr, b_mwdat;
   logic [1:0]  b_mrrdy = '0;
   logic [15:0] b_mrdat = '0;
   logic [3:0]  b_wr_vld  = '0;
   logic [31:0] b_wr_addr = '0;
   logic [31:0] b_wr_dat  = '0;
   logic [1:0]  b_mwrdy   = '0;
`ifdef MEM_ARB_PERF_EN
   logic [15:0] b_pg, b_ps;
`endif

   mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) u_b (
      .clk                    (clk),
      .reset                  (b_reset),
`ifdef MEM_ARB_PERF_EN
      .perf_grant_count       (b_pg),
      .perf_stall_count       (b_ps),
`endif
      .consumer_read_valid    (b_rd_vld),
      .consumer_read_address  (b_rd_addr),
      .consumer_read_ready    (b_crr),
      .consumer_read_data     (b_rdata),
      .consumer_write_valid   (b_wr_vld),
      .consumer_write_address (b_wr_addr),
      .consumer_write_data    (b_wr_dat),
      .consumer_write_ready   (b_cwr),
      .mem_read_valid         (b_mrv),
      .mem_read_address       (b_mraddr),
      .mem_read_ready         (b_mrrdy),
      .mem_read_data          (b_mrdat),
      .mem_write_valid        (b_mwv),
      .mem_write_address      (b_mwaddr),
      .mem_write_data         (b_mwdat),
      .mem_write_ready        (b_mwrdy)
   );

   // ---------------- memory models (falling edge) ----------------
   int rd_delay = 0;
   int wr_delay = 0;
   int rd_cnt   = 0;
   int wr_cnt   = 0;

   always @(negedge clk) begin
      if (a_mrv) begin
         if (rd_cnt == rd_delay) begin
            a_mrrdy = 1'b1;
            a_mrdat = 8'hA0 + a_mraddr;
         end else begin
            a_mrrdy = 1'b0;
         end
         rd_cnt = rd_cnt + 1;
      end else begin
         a_mrrdy = 1'b0;
         rd_cnt  = 0;
      end
      if (a_mwv) begin
         a_mwrdy = (wr_cnt == wr_delay);
         wr_cnt  = wr_cnt + 1;
      end else begin
         a_mwrdy = 1'b0;
         wr_cnt  = 0;
      end
      for (int c = 0; c < 2; c++) begin
         b_mrrdy[c] = b_mrv[c];
         if (b_mrv[c]) b_mrdat[c*8 +: 8] = 8'hA0 + b_mraddr[c*8 +: 8];
      end
   end

   always @(posedge clk) begin
      #2;
      checks = checks + 1;
      if ((a_mrv & a_mwv) !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL mon_a_rw_overlap at %0t", $time);
      end
      checks = checks + 1;
      if ((b_crr & b_cwr) !== 4'b0000) begin
         errors = errors + 1;
         $display("FAIL mon_b_ready_overlap at %0t", $time);
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle vectors for the N=4,M=1 round-robin sweep.
   typedef struct packed {
      logic [3:0]  rd;      // lane read_valid applied before the edge
      logic        mrv;     // expected mem_read_valid after the edge
      logic [7:0]  maddr;   // expected mem_read_address when mrv is expected
      logic [3:0]  crr;     // expected consumer_read_ready
      logic [31:0] rdata;   // expected consumer_read_data
   } vec_t;

   vec_t tbl [12];

   initial begin
      tbl[0]  = '{4'b1111, 1'b1, 8'h00, 4'b0000, 32'h00000000};
      tbl[1]  = '{4'b1111, 1'b0, 8'h00, 4'b0001, 32'h000000A0};
      tbl[2]  = '{4'b1110, 1'b0, 8'h00, 4'b0000, 32'h000000A0};
      tbl[3]  = '{4'b1110, 1'b1, 8'h01, 4'b0000, 32'h000000A0};
      tbl[4]  = '{4'b1110, 1'b0, 8'h00, 4'b0010, 32'h0000A1A0};
      tbl[5]  = '{4'b1100, 1'b0, 8'h00, 4'b0000, 32'h0000A1A0};
      tbl[6]  = '{4'b1100, 1'b1, 8'h02, 4'b0000, 32'h0000A1A0};
      tbl[7]  = '{4'b1100, 1'b0, 8'h00, 4'b0100, 32'h00A2A1A0};
      tbl[8]  = '{4'b1000, 1'b0, 8'h00, 4'b0000, 32'h00A2A1A0};
      tbl[9]  = '{4'b1000, 1'b1, 8'h03, 4'b0000, 32'h00A2A1A0};
      tbl[10] = '{4'b1000, 1'b0, 8'h00, 4'b1000, 32'hA3A2A1A0};
      tbl[11] = '{4'b0000, 1'b0, 8'h00, 4'b0000, 32'hA3A2A1A0};

      // Reset state
      repeat (3) step();
      `CHK("rst_mrv", a_mrv, 1'b0);
      `CHK("rst_maddr", a_mraddr, 8'h00);
      `CHK("rst_mwv", a_mwv, 1'b0);
      `CHK("rst_mwaddr", a_mwaddr, 8'h00);
      `CHK("rst_mwdat", a_mwdat, 8'h00);
      `CHK("rst_crr", a_crr, 4'b0000);
      `CHK("rst_cwr", a_cwr, 4'b0000);
      `CHK("rst_rdata", a_rdata, 32'h0);
      `CHK("rst_b_mrv", b_mrv, 2'b00);

      // Round-robin sweep: all lanes read-valid at reset release
      for (int k = 0; k < 12; k++) begin
         if (k == 0) a_reset = 1'b0;
         a_rd_vld = tbl[k].rd;
         step();
         `CHK($sformatf("rr%0d_mrv", k), a_mrv, tbl[k].mrv);
         if (tbl[k].mrv) `CHK($sformatf("rr%0d_maddr", k), a_mraddr, tbl[k].maddr);
         `CHK($sformatf("rr%0d_crr", k), a_crr, tbl[k].crr);
         `CHK($sformatf("rr%0d_rdata", k), a_rdata, tbl[k].rdata);
         `CHK($sformatf("rr%0d_mwv", k), a_mwv, 1'b0);
      end

      // Lane 2 with read and write both valid: read first, write after relay
      a_rd_addr[23:16] = 8'h10;
      a_wr_addr[23:16] = 8'h10;
      a_wr_dat[23:16]  = 8'h55;
      a_rd_vld = 4'b0100;
      a_wr_vld = 4'b0100;
      step();
      `CHK("rw_rd_first_mrv", a_mrv, 1'b1);
      `CHK("rw_rd_addr", a_mraddr, 8'h10);
      `CHK("rw_no_write_yet", a_mwv, 1'b0);
      step();
      `CHK("rw_crr", a_crr, 4'b0100);
      `CHK("rw_cwr_low", a_cwr, 4'b0000);
      `CHK("rw_rdata2", a_rdata[23:16], 8'hB0);
      `CHK("rw_relay_mwv", a_mwv, 1'b0);
      a_rd_vld = 4'b0000;
      step();
      `CHK("rw_release_crr", a_crr, 4'b0000);
      `CHK("rw_release_mwv", a_mwv, 1'b0);
      step();
      `CHK("rw_wr_mwv", a_mwv, 1'b1);
      `CHK("rw_wr_addr", a_mwaddr, 8'h10);
      `CHK("rw_wr_dat", a_mwdat, 8'h55);
      `CHK("rw_wr_mrv", a_mrv, 1'b0);
      step();
      `CHK("rw_cwr", a_cwr, 4'b0100);
      a_wr_vld = 4'b0000;
      step();
      `CHK("rw_cwr_drop", a_cwr, 4'b0000);

      // Write with memory ready delayed 5 cycles (lane 1)
      wr_delay = 4;
      a_wr_addr[15:8] = 8'h33;
      a_wr_dat[15:8]  = 8'h77;
      a_wr_vld = 4'b0010;
      step();
      `CHK("wd_mwv0", a_mwv, 1'b1);
      `CHK("wd_addr", a_mwaddr, 8'h33);
      `CHK("wd_dat", a_mwdat, 8'h77);
      for (int k = 1; k < 5; k++) begin
         step();
         `CHK($sformatf("wd_mwv%0d", k), a_mwv, 1'b1);
         `CHK($sformatf("wd_cwr%0d", k), a_cwr, 4'b0000);
      end
      step();
      `CHK("wd_done_mwv", a_mwv, 1'b0);
      `CHK("wd_done_cwr", a_cwr, 4'b0010);
      for (int k = 0; k < 3; k++) begin
         step();
         `CHK($sformatf("wd_hold_cwr%0d", k), a_cwr, 4'b0010);
      end
      a_wr_vld = 4'b0000;
      step();
      `CHK("wd_drop_cwr", a_cwr, 4'b0000);
      wr_delay = 0;

      // Reset during READ_WAIT; arbitration restarts from lane 0
      rd_delay = 100;
      a_rd_addr[15:8]  = 8'h21;
      a_rd_addr[31:24] = 8'h23;
      a_rd_vld = 4'b1010;
      step();
      `CHK("rw_grant3_mrv", a_mrv, 1'b1);
      `CHK("rw_grant3_addr", a_mraddr, 8'h23);
      step();
      `CHK("rw_wait_mrv", a_mrv, 1'b1);
      a_reset = 1'b1;
      step();
      `CHK("mid_rst_mrv", a_mrv, 1'b0);
      `CHK("mid_rst_maddr", a_mraddr, 8'h00);
      `CHK("mid_rst_rdata", a_rdata, 32'h0);
      `CHK("mid_rst_crr", a_crr, 4'b0000);
      `CHK("mid_rst_cwr", a_cwr, 4'b0000);
      `CHK("mid_rst_mwv", a_mwv, 1'b0);
      `CHK("mid_rst_mwaddr", a_mwaddr, 8'h00);
      `CHK("mid_rst_mwdat", a_mwdat, 8'h00);
      a_reset  = 1'b0;
      rd_delay = 0;
      step();
      `CHK("post_rst_mrv", a_mrv, 1'b1);
      `CHK("post_rst_addr", a_mraddr, 8'h21);
      step();
      `CHK("post_rst_crr", a_crr, 4'b0010);
      `CHK("post_rst_rdata1", a_rdata[15:8], 8'hC1);
      a_rd_vld = 4'b1000;
      step();
      step();
      `CHK("post_rst_addr3", a_mraddr, 8'h23);
      step();
      `CHK("post_rst_crr3", a_crr, 4'b1000);
      `CHK("post_rst_rdata3", a_rdata[31:24], 8'hC3);
      a_rd_vld = 4'b0000;
      step();

      // Three reads with two stall cycles (lane 1 waits while the channel is busy)
      a_reset = 1'b1;
      step();
      a_reset = 1'b0;
`ifdef MEM_ARB_PERF_EN
      `CHK("perf_rst_grant", a_pg, 16'd0);
      `CHK("perf_rst_stall", a_ps, 16'd0);
`endif
      a_rd_vld = 4'b0001;
      step();
      a_rd_vld = 4'b0011;
      step();
      `CHK("pf_crr0", a_crr, 4'b0001);
      a_rd_vld = 4'b0010;
      step();
      step();
      `CHK("pf_addr1", a_mraddr, 8'h21);
      step();
      `CHK("pf_crr1", a_crr, 4'b0010);
      a_rd_vld = 4'b0000;
      step();
      a_rd_vld = 4'b0100;
      step();
      `CHK("pf_addr2", a_mraddr, 8'h10);
      step();
      `CHK("pf_crr2", a_crr, 4'b0100);
      a_rd_vld = 4'b0000;
      step();
`ifdef MEM_ARB_PERF_EN
      `CHK("perf_grant", a_pg, 16'd3);
      `CHK("perf_stall", a_ps, 16'd2);
`endif

      // Two channels: same-cycle grants, then claim visibility across channels
      b_rd_addr = 32'h00004140;
      b_reset   = 1'b0;
      b_rd_vld  = 4'b0011;
      step();
      `CHK("mc_mrv", b_mrv, 2'b11);
      `CHK("mc_addr", b_mraddr, 16'h4140);
      step();
      `CHK("mc_crr", b_crr, 4'b0011);
      `CHK("mc_rdata", b_rdata[15:0], 16'hE1E0);
      b_rd_vld = 4'b0000;
      step();
      `CHK("mc_release", b_crr, 4'b0000);
      b_rd_vld = 4'b0001;
      step();
      `CHK("mc_single_grant", b_mrv, 2'b01);
      `CHK("mc_single_addr", b_mraddr[7:0], 8'h40);
      step();
      `CHK("mc_single_crr", b_crr, 4'b0001);
      `CHK("mc_single_idle", b_mrv, 2'b00);
      b_rd_vld = 4'b0000;
      step();
      `CHK("mc_single_rel", b_crr, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
